// File: rtl/pc_branch_unit.sv
// -----------------------------------------------------------------------------
// pc_branch_unit
//   Parametrised program-counter sequencer: increment, relative branch,
//   absolute load and vector load. A branch that leaves the current page is
//   completed 6502-style: the low part is written first and the high part is
//   corrected on the following edge (FIXUP state).
//
//   Optional feature macro: PC_FAST_BRANCH_EN
//     undefined (default) - page-crossing branch takes two cycles via FIXUP
//     defined             - FIXUP removed, full target written in one cycle,
//                           CMD_READY tied high
//
// Ports
//   CLK        in   clock, rising edge
//   RES_N      in   asynchronous active-low reset
//   CMD        in   0 HOLD, 1 INC, 2 BRANCH, 3 LOAD, 4 VECTOR, 5-7 HOLD
//   CMD_VALID  in   CMD is valid this cycle
//   CMD_READY  out  unit accepts a command this cycle
//   OFFSET     in   signed relative branch offset
//   LOAD_DATA  in   absolute target for LOAD
//   VEC_ADDR   in   target for VECTOR
//   PC         out  current program counter (registered)
//   PAGE_CROSS out  one-cycle pulse after a branch crossed a page (registered)
//   BUSY       out  high while the high-part correction is pending
// -----------------------------------------------------------------------------
module pc_branch_unit #(
    parameter int                ADDR_W   = 16,
    parameter int                PAGE_W   = 8,
    parameter int                OFF_W    = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000
) (
    input  logic              CLK,
    input  logic              RES_N,
    input  logic [2:0]        CMD,
    input  logic              CMD_VALID,
    output logic              CMD_READY,
    input  logic [OFF_W-1:0]  OFFSET,
    input  logic [ADDR_W-1:0] LOAD_DATA,
    input  logic [ADDR_W-1:0] VEC_ADDR,
    output logic [ADDR_W-1:0] PC,
    output logic              PAGE_CROSS,
    output logic              BUSY
);

    localparam int                HI_W     = ADDR_W - PAGE_W;
    localparam logic [2:0]        CMD_INC    = 3'd1;
    localparam logic [2:0]        CMD_BRANCH = 3'd2;
    localparam logic [2:0]        CMD_LOAD   = 3'd3;
    localparam logic [2:0]        CMD_VECTOR = 3'd4;
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [ADDR_W-1:0] pc_r;
    logic [ADDR_W-1:0] pc_nxt_s;
    logic              page_cross_r;
    logic              page_cross_nxt_s;
    logic              accept_s;
    logic [ADDR_W-1:0] off_ext_s;
    logic [ADDR_W-1:0] target_s;
    logic              cross_s;

    // Branch target: sign-extended offset added over the full PC width; the
    // low part of this sum equals the page-local sum, so one adder serves both.
    always_comb begin
        off_ext_s = {{(ADDR_W-OFF_W){OFFSET[OFF_W-1]}}, OFFSET};
        target_s  = pc_r + off_ext_s;
        cross_s   = (target_s[ADDR_W-1:PAGE_W] != pc_r[ADDR_W-1:PAGE_W]);
    end

    assign accept_s   = CMD_VALID & CMD_READY;
    assign PC         = pc_r;
    assign PAGE_CROSS = page_cross_r;

`ifdef PC_FAST_BRANCH_EN

    assign CMD_READY = 1'b1;
    assign BUSY      = 1'b0;

    // Next-PC selection; a crossing branch lands on the full target at once.
    always_comb begin
        pc_nxt_s         = pc_r;
        page_cross_nxt_s = 1'b0;
        if (accept_s) begin
            case (CMD)
                CMD_INC:    pc_nxt_s = pc_r + ADDR_ONE;
                CMD_BRANCH: begin
                    pc_nxt_s         = target_s;
                    page_cross_nxt_s = cross_s;
                end
                CMD_LOAD:   pc_nxt_s = LOAD_DATA;
                CMD_VECTOR: pc_nxt_s = VEC_ADDR;
                default:    pc_nxt_s = pc_r;
            endcase
        end else begin
            pc_nxt_s = pc_r;
        end
    end

`else

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FIXUP = 1'b1
    } state_t;

    localparam logic [HI_W-1:0] HI_ONE = {{(HI_W-1){1'b0}}, 1'b1};

    state_t            state_r;
    state_t            state_nxt_s;
    logic              dir_neg_r;
    logic              dir_neg_nxt_s;
    logic [HI_W-1:0]   hi_fix_s;

    assign CMD_READY = (state_r == ST_IDLE);
    assign BUSY      = (state_r == ST_FIXUP);

    // Corrected high part; OFF_W <= PAGE_W bounds a crossing to one page,
    // so the correction is always exactly +1 or -1 (wrapping).
    always_comb begin
        if (dir_neg_r) begin
            hi_fix_s = pc_r[ADDR_W-1:PAGE_W] - HI_ONE;
        end else begin
            hi_fix_s = pc_r[ADDR_W-1:PAGE_W] + HI_ONE;
        end
    end

    // Next-state and next-PC logic for the IDLE/FIXUP sequencer.
    always_comb begin
        pc_nxt_s         = pc_r;
        page_cross_nxt_s = 1'b0;
        state_nxt_s      = state_r;
        dir_neg_nxt_s    = dir_neg_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    case (CMD)
                        CMD_INC:    pc_nxt_s = pc_r + ADDR_ONE;
                        CMD_BRANCH: begin
                            if (cross_s) begin
                                pc_nxt_s      = {pc_r[ADDR_W-1:PAGE_W], target_s[PAGE_W-1:0]};
                                dir_neg_nxt_s = OFFSET[OFF_W-1];
                                state_nxt_s   = ST_FIXUP;
                            end else begin
                                pc_nxt_s      = target_s;
                            end
                        end
                        CMD_LOAD:   pc_nxt_s = LOAD_DATA;
                        CMD_VECTOR: pc_nxt_s = VEC_ADDR;
                        default:    pc_nxt_s = pc_r;
                    endcase
                end else begin
                    pc_nxt_s = pc_r;
                end
            end
            ST_FIXUP: begin
                pc_nxt_s         = {hi_fix_s, pc_r[PAGE_W-1:0]};
                page_cross_nxt_s = 1'b1;
                state_nxt_s      = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Sequencer state and pending correction direction.
    always_ff @(posedge CLK or negedge RES_N) begin
        if (!RES_N) begin
            state_r   <= ST_IDLE;
            dir_neg_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            dir_neg_r <= dir_neg_nxt_s;
        end
    end

`endif

    // PC and page-cross pulse registers.
    always_ff @(posedge CLK or negedge RES_N) begin
        if (!RES_N) begin
            pc_r         <= RESET_PC;
            page_cross_r <= 1'b0;
        end else begin
            pc_r         <= pc_nxt_s;
            page_cross_r <= page_cross_nxt_s;
        end
    end

endmodule

// File: tb/tb_pc_branch_unit.sv
// -----------------------------------------------------------------------------
// tb_pc_branch_unit
//   Directed corner cases plus randomized command stream for pc_branch_unit,
//   checked against a behavioural PC model working on plain integers.
// -----------------------------------------------------------------------------
module tb_pc_branch_unit;

    logic        CLK = 1'b0;
    logic        RES_N = 1'b0;
    logic [2:0]  CMD = 3'd0;
    logic        CMD_VALID = 1'b0;
    logic        CMD_READY;
    logic [7:0]  OFFSET = 8'h00;
    logic [15:0] LOAD_DATA = 16'h0000;
    logic [15:0] VEC_ADDR = 16'h0000;
    logic [15:0] PC;
    logic        PAGE_CROSS;
    logic        BUSY;

    int n_vec = 0;
    int n_bad = 0;

    // model state
    int m_pc    = 0;
    bit m_fix   = 1'b0;
    int m_tgt   = 0;
    bit m_cross = 1'b0;

    pc_branch_unit #(
        .ADDR_W  (16),
        .PAGE_W  (8),
        .OFF_W   (8),
        .RESET_PC(16'h0000)
    ) dut (
        .CLK       (CLK),
        .RES_N     (RES_N),
        .CMD       (CMD),
        .CMD_VALID (CMD_VALID),
        .CMD_READY (CMD_READY),
        .OFFSET    (OFFSET),
        .LOAD_DATA (LOAD_DATA),
        .VEC_ADDR  (VEC_ADDR),
        .PC        (PC),
        .PAGE_CROSS(PAGE_CROSS),
        .BUSY      (BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag);
        check_eq({tag, "_pc"}, {16'h0000, PC}, m_pc);
        check_eq({tag, "_cross"}, {31'd0, PAGE_CROSS}, {31'd0, m_cross});
        check_eq({tag, "_ready"}, {31'd0, CMD_READY}, {31'd0, ~m_fix});
        check_eq({tag, "_busy"}, {31'd0, BUSY}, {31'd0, m_fix});
    endtask

    // Behavioural reference: what the PC should be after one clock edge.
    task automatic model_edge(input int c, input bit v, input int off_u, input int ld, input int vec);
        int o;
        int t;
        if (m_fix) begin
            m_pc    = m_tgt;
            m_fix   = 1'b0;
            m_cross = 1'b1;
        end else begin
            m_cross = 1'b0;
            if (v) begin
                case (c)
                    1: m_pc = (m_pc + 1) % 65536;
                    2: begin
                        o = (off_u >= 128) ? off_u - 256 : off_u;
                        t = (m_pc + o + 65536) % 65536;
                        if ((t / 256) == (m_pc / 256)) begin
                            m_pc = t;
                        end else begin
`ifdef PC_FAST_BRANCH_EN
                            m_pc    = t;
                            m_cross = 1'b1;
`else
                            m_pc  = (m_pc / 256) * 256 + (t % 256);
                            m_fix = 1'b1;
                            m_tgt = t;
`endif
                        end
                    end
                    3: m_pc = ld;
                    4: m_pc = vec;
                    default: m_pc = m_pc;
                endcase
            end
        end
    endtask

    // One clock: drive inputs, take the edge, sample 1 time unit later.
    task automatic cycle(input string tag, input logic [2:0] c, input logic v,
                         input logic [7:0] off, input logic [15:0] ld, input logic [15:0] vec);
        CMD       = c;
        CMD_VALID = v;
        OFFSET    = off;
        LOAD_DATA = ld;
        VEC_ADDR  = vec;
        model_edge(int'(c), v, int'(off), int'(ld), int'(vec));
        @(posedge CLK);
        #1;
        check_outputs(tag);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear before the next edge.
    task automatic async_reset(input string tag);
        #2;
        RES_N = 1'b0;
        m_pc    = 0;
        m_fix   = 1'b0;
        m_cross = 1'b0;
        #1;
        check_outputs(tag);
        @(negedge CLK);
        RES_N = 1'b1;
    endtask

    initial begin
        int c;
        bit v;
        logic [15:0] ld;
        logic [7:0]  off;

        #3;
        check_outputs("rst0");
        @(negedge CLK);
        RES_N = 1'b1;

        // increment, wrap, hold
        cycle("ld12ff", 3'd3, 1'b1, 8'h00, 16'h12FF, 16'h0000);
        cycle("inc12ff", 3'd1, 1'b1, 8'h00, 16'h0000, 16'h0000);
        check_eq("inc_to_1300", {16'h0000, PC}, 32'h0000_1300);
        cycle("ldffff", 3'd3, 1'b1, 8'h00, 16'hFFFF, 16'h0000);
        cycle("incwrap", 3'd1, 1'b1, 8'h00, 16'h0000, 16'h0000);
        check_eq("inc_wrap_0", {16'h0000, PC}, 32'h0000_0000);
        cycle("incnv", 3'd1, 1'b0, 8'h00, 16'h0000, 16'h0000);

        // in-page branch
        cycle("ld1210", 3'd3, 1'b1, 8'h00, 16'h1210, 16'h0000);
        cycle("br_inpage", 3'd2, 1'b1, 8'h05, 16'h0000, 16'h0000);
        check_eq("br_1215", {16'h0000, PC}, 32'h0000_1215);

        // forward crossing, LOAD offered during the fix-up
        cycle("ld12f0", 3'd3, 1'b1, 8'h00, 16'h12F0, 16'h0000);
        cycle("fwd_e1", 3'd2, 1'b1, 8'h20, 16'h0000, 16'h0000);
`ifdef PC_FAST_BRANCH_EN
        check_eq("fwd_fast", {16'h0000, PC}, 32'h0000_1310);
`else
        check_eq("fwd_e1_1210", {16'h0000, PC}, 32'h0000_1210);
`endif
        cycle("fwd_e2", 3'd3, 1'b1, 8'h00, 16'hAAAA, 16'h0000);
        cycle("fwd_e3", 3'd0, 1'b0, 8'h00, 16'h0000, 16'h0000);

        // backward crossings, including high-part wrap
        cycle("ld1205", 3'd3, 1'b1, 8'h00, 16'h1205, 16'h0000);
        cycle("bwd_e1", 3'd2, 1'b1, 8'hF0, 16'h0000, 16'h0000);
        cycle("bwd_e2", 3'd0, 1'b0, 8'h00, 16'h0000, 16'h0000);
        check_eq("bwd_11f5", {16'h0000, PC}, 32'h0000_11F5);
        cycle("ld0005", 3'd3, 1'b1, 8'h00, 16'h0005, 16'h0000);
        cycle("wrap_e1", 3'd2, 1'b1, 8'h80, 16'h0000, 16'h0000);
        cycle("wrap_e2", 3'd0, 1'b0, 8'h00, 16'h0000, 16'h0000);
        check_eq("wrap_ff85", {16'h0000, PC}, 32'h0000_FF85);

        // zero-offset branch is a no-op
        cycle("br_zero", 3'd2, 1'b1, 8'h00, 16'h0000, 16'h0000);

        // reset during the fix-up, then a vector load
        cycle("ld12f0b", 3'd3, 1'b1, 8'h00, 16'h12F0, 16'h0000);
        cycle("fix_pre", 3'd2, 1'b1, 8'h20, 16'h0000, 16'h0000);
        async_reset("rst_fix");
        cycle("post_rst", 3'd0, 1'b0, 8'h00, 16'h0000, 16'h0000);
        cycle("vector", 3'd4, 1'b1, 8'h00, 16'h0000, 16'hFFFC);
        check_eq("vec_fffc", {16'h0000, PC}, 32'h0000_FFFC);

        // randomized command stream
        for (int i = 0; i < 600; i++) begin
            c   = $urandom_range(0, 7);
            if (($urandom_range(0, 3)) != 0 && c > 4) c = 2;
            v   = ($urandom_range(0, 7) != 0);
            off = 8'($urandom);
            ld  = 16'($urandom);
            if ($urandom_range(0, 3) == 0) ld[15:8] = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00;
            cycle("rnd", 3'(c), v, off, ld, 16'($urandom));
            if ($urandom_range(0, 79) == 0) begin
                async_reset("rnd_rst");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
